// File: rtl/inst_fetch_buffer.sv
// Instruction fetch buffer: issues in-order imem reads at the PC, holds up to
// DEPTH instructions with their PCs, and hands them to decode via valid/ready.
module inst_fetch_buffer #(
  parameter int DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_pc,
  output logic        o_pc_advance,
  input  logic        i_flush,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_id_valid,
  input  logic        i_id_ready,
  output logic [31:0] o_id_inst,
  output logic [31:0] o_id_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_PENDING,
    ST_FULL
  } entry_state_t;

  entry_state_t  r_state [DEPTH];
  logic [31:0]   r_pc    [DEPTH];
  logic [31:0]   r_inst  [DEPTH];

  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_fptr;
  logic [PW-1:0] r_rptr;
  logic [PW-1:0] r_discard;
  logic          r_run;

  logic [AW-1:0] w_widx;
  logic [AW-1:0] w_fidx;
  logic [AW-1:0] w_ridx;
  logic [PW-1:0] w_alloc;
  logic [PW-1:0] w_pend;
  logic [PW-1:0] w_outstanding;
  logic [PW-1:0] w_flush_discard;
  logic          w_grant;
  logic          w_fill;
  logic          w_drop;
  logic          w_pop;

  assign w_widx  = r_wptr[AW-1:0];
  assign w_fidx  = r_fptr[AW-1:0];
  assign w_ridx  = r_rptr[AW-1:0];
  assign w_alloc = r_wptr - r_rptr;
  assign w_pend  = r_wptr - r_fptr;

  assign o_imem_req   = r_run & ~i_flush & (w_alloc < DEPTH_P) & (r_discard == '0);
  assign o_imem_addr  = i_pc;
  assign w_grant      = o_imem_req & i_imem_gnt;
  assign o_pc_advance = w_grant;

  // A response with nothing pending and nothing to discard is stray and ignored.
  assign w_drop = i_imem_rvalid & (r_discard != '0);
  assign w_fill = i_imem_rvalid & (r_discard == '0) & (w_pend != '0);

  assign o_id_valid = (r_state[w_ridx] == ST_FULL);
  assign o_id_inst  = r_inst[w_ridx];
  assign o_id_pc    = r_pc[w_ridx];
  assign w_pop      = o_id_valid & i_id_ready;

  // Responses still owed to dead requests; a same-cycle response retires one of them.
  assign w_outstanding   = r_discard + w_pend;
  assign w_flush_discard = (i_imem_rvalid && (w_outstanding != '0)) ?
                           (w_outstanding - PW'(1)) : w_outstanding;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_run     <= 1'b0;
      r_wptr    <= '0;
      r_fptr    <= '0;
      r_rptr    <= '0;
      r_discard <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_state[i] <= ST_EMPTY;
        r_pc[i]    <= '0;
        r_inst[i]  <= '0;
      end
    end else begin
      r_run <= 1'b1;
      if (i_flush) begin
        r_wptr    <= '0;
        r_fptr    <= '0;
        r_rptr    <= '0;
        r_discard <= w_flush_discard;
        for (int i = 0; i < DEPTH; i++) begin
          r_state[i] <= ST_EMPTY;
        end
      end else begin
        if (w_drop) begin
          r_discard <= r_discard - PW'(1);
        end
        if (w_grant) begin
          r_state[w_widx] <= ST_PENDING;
          r_pc[w_widx]    <= i_pc;
          r_wptr          <= r_wptr + PW'(1);
        end
        if (w_fill) begin
          r_state[w_fidx] <= ST_FULL;
          r_inst[w_fidx]  <= i_imem_rdata;
          r_fptr          <= r_fptr + PW'(1);
        end
        if (w_pop) begin
          r_state[w_ridx] <= ST_EMPTY;
          r_rptr          <= r_rptr + PW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Randomized bench for inst_fetch_buffer; a queue-based model of buffered
// instructions and owed responses predicts every output each cycle.
module tb_inst_fetch_buffer;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rstN;
  logic [31:0] pcIn;
  logic        pcAdvance;
  logic        flush;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemGnt;
  logic        imemRvalid;
  logic [31:0] imemRdata;
  logic        idValid;
  logic        idReady;
  logic [31:0] idInst;
  logic [31:0] idPc;

  inst_fetch_buffer #(.DEPTH(DEPTH)) dut (
    .i_clk        (clk),
    .i_rst_n      (rstN),
    .i_pc         (pcIn),
    .o_pc_advance (pcAdvance),
    .i_flush      (flush),
    .o_imem_req   (imemReq),
    .o_imem_addr  (imemAddr),
    .i_imem_gnt   (imemGnt),
    .i_imem_rvalid(imemRvalid),
    .i_imem_rdata (imemRdata),
    .o_id_valid   (idValid),
    .i_id_ready   (idReady),
    .o_id_inst    (idInst),
    .o_id_pc      (idPc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    bit          full;
  } entry_t;

  entry_t      modelQ[$];
  int          deadOwed;
  bit          modelRun;
  logic [31:0] pcReg;
  int          errors = 0;
  int          checks = 0;
  int          pGnt, pReady, pRvalid, pFlush;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int pendingCount();
    int n = 0;
    foreach (modelQ[i]) if (!modelQ[i].full) n++;
    return n;
  endfunction

  function automatic bit chance(input int pct);
    return ($urandom_range(0, 99) < pct);
  endfunction

  // Called just after a falling edge: drive inputs, check outputs, advance the model.
  task automatic applyStimulus();
    bit   expReq, expAdv, frontFull, doPop;
    int   owed, total;
    pcIn       = pcReg;
    imemGnt    = chance(pGnt);
    idReady    = chance(pReady);
    flush      = chance(pFlush);
    owed       = pendingCount() + deadOwed;
    imemRvalid = (owed > 0) ? chance(pRvalid) : chance(3);
    imemRdata  = $urandom;
    #1;
    expReq    = modelRun && !flush && (modelQ.size() < DEPTH) && (deadOwed == 0);
    expAdv    = expReq && imemGnt;
    frontFull = (modelQ.size() > 0) && modelQ[0].full;
    checkOutput("imem_req", 32'(imemReq), 32'(expReq));
    checkOutput("pc_advance", 32'(pcAdvance), 32'(expAdv));
    checkOutput("imem_addr", imemAddr, pcReg);
    checkOutput("id_valid", 32'(idValid), 32'(frontFull));
    if (frontFull) begin
      checkOutput("id_pc", idPc, modelQ[0].pc);
      checkOutput("id_inst", idInst, modelQ[0].inst);
    end
    if (flush) begin
      total = deadOwed + pendingCount();
      if (imemRvalid && total > 0) total--;
      deadOwed = total;
      modelQ.delete();
      pcReg = 32'h200 + 32'($urandom_range(0, 255)) * 32'd4;
    end else begin
      doPop = frontFull && idReady;
      if (imemRvalid) begin
        if (deadOwed > 0) begin
          deadOwed--;
        end else begin
          for (int i = 0; i < modelQ.size(); i++) begin
            if (!modelQ[i].full) begin
              modelQ[i].full = 1'b1;
              modelQ[i].inst = imemRdata;
              break;
            end
          end
        end
      end
      if (doPop) void'(modelQ.pop_front());
      if (expAdv) begin
        modelQ.push_back('{pc: pcReg, inst: 32'h0, full: 1'b0});
        pcReg = pcReg + 32'd4;
      end
    end
    modelRun = 1'b1;
  endtask

  task automatic runCycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      applyStimulus();
    end
  endtask

  task automatic setMode(input int g, input int r, input int v, input int f);
    pGnt = g; pReady = r; pRvalid = v; pFlush = f;
  endtask

  // Assert reset mid-cycle, check it takes effect at once, then release.
  task automatic doReset();
    @(posedge clk);
    #2;
    rstN = 1'b0;
    flush = 1'b0; imemGnt = 1'b0; imemRvalid = 1'b0; idReady = 1'b0;
    #1;
    modelQ.delete();
    deadOwed = 0;
    modelRun = 1'b0;
    pcReg    = 32'h0;
    pcIn     = pcReg;
    #1;
    checkOutput("rst id_valid", 32'(idValid), 32'h0);
    checkOutput("rst imem_req", 32'(imemReq), 32'h0);
    checkOutput("rst pc_advance", 32'(pcAdvance), 32'h0);
    checkOutput("rst id_inst", idInst, 32'h0);
    checkOutput("rst id_pc", idPc, 32'h0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    applyStimulus();
  endtask

  initial begin
    rstN = 1'b0; pcIn = 32'h0; flush = 1'b0; imemGnt = 1'b0;
    imemRvalid = 1'b0; imemRdata = 32'h0; idReady = 1'b0;
    deadOwed = 0; modelRun = 1'b0; pcReg = 32'h0;
    setMode(100, 100, 100, 0);
    doReset();

    // Streaming from pc 0 with the memory answering every cycle.
    runCycles(40);
    // Backpressure, then drain.
    setMode(100, 0, 100, 0);
    runCycles(6);
    setMode(100, 100, 100, 0);
    runCycles(10);
    // Grant stall.
    setMode(0, 100, 100, 0);
    runCycles(3);
    setMode(100, 100, 100, 0);
    runCycles(5);
    // Mixed random traffic with occasional redirects.
    setMode(60, 60, 50, 8);
    runCycles(2000);
    // Redirect-heavy traffic exercising the discard path.
    setMode(80, 70, 60, 30);
    runCycles(500);
    // Fill the buffer, then reset mid-stream.
    setMode(100, 0, 100, 0);
    runCycles(5);
    doReset();
    setMode(100, 100, 100, 0);
    runCycles(20);
    setMode(50, 50, 70, 10);
    runCycles(500);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
